// File: rtl/ram_march_bist.sv
// rtl/ram_march_bist.sv - march-style BIST initiator for the dual-port RAM
//
// Runs four passes over the whole RAM:
//   write PATTERN ascending, read back ascending,
//   write ~PATTERN descending, read back descending.
// Every read is compared one cycle later against the expected background.
// Mismatches are counted, saturating, and the first failing address is kept.
//
// Ports
//   clk              in   rising-edge clock
//   rst              in   synchronous active-high reset
//   start            in   single-cycle run request, honoured in IDLE/DONE only
//   dout             in   RAM read data, valid the cycle after rd_en
//   din              out  RAM write data
//   addr_wr          out  RAM write address
//   addr_rd          out  RAM read address
//   wr_en            out  RAM write enable
//   rd_en            out  RAM read enable
//   busy             out  run in progress (WR_P through FLUSH)
//   done             out  run finished, results stable
//   pass             out  done with zero mismatches
//   err_cnt          out  saturating mismatch count
//   first_fail_addr  out  address of first mismatch of the run, 0 if none

module ram_march_bist #(
    parameter int                   MEM_WIDTH = 8,
    parameter int                   MEM_DEPTH = 256,
    parameter int                   ADDR_SIZE = $clog2(MEM_DEPTH),
    parameter logic [MEM_WIDTH-1:0] PATTERN   = 8'hA5,
    parameter int                   ERR_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [MEM_WIDTH-1:0] dout,
    output logic [MEM_WIDTH-1:0] din,
    output logic [ADDR_SIZE-1:0] addr_wr,
    output logic [ADDR_SIZE-1:0] addr_rd,
    output logic                 wr_en,
    output logic                 rd_en,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_cnt,
    output logic [ADDR_SIZE-1:0] first_fail_addr
);

    localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_P  = 3'd1,
        RD_P  = 3'd2,
        WR_NP = 3'd3,
        RD_NP = 3'd4,
        FLUSH = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t               state;
    logic [ADDR_SIZE-1:0] cnt;

    // Compare pipeline: one stage holding what the RAM is returning this cycle.
    logic                 chk_v;
    logic [MEM_WIDTH-1:0] chk_exp;
    logic [ADDR_SIZE-1:0] chk_addr;

    logic                 mismatch;
    logic                 err_sat;
    logic [ERR_W-1:0]     err_nxt;

    always_comb begin
        mismatch = chk_v && (dout != chk_exp);
        err_sat  = &err_cnt;
        err_nxt  = err_cnt;
        if (mismatch && !err_sat) begin
            err_nxt = err_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            wr_en           <= 1'b0;
            rd_en           <= 1'b0;
            din             <= '0;
            addr_wr         <= '0;
            addr_rd         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_cnt         <= '0;
            first_fail_addr <= '0;
            chk_v           <= 1'b0;
            chk_exp         <= '0;
            chk_addr        <= '0;
        end else begin
            // Capture the read issued this cycle; its data arrives next cycle.
            chk_v <= rd_en;
            if (rd_en) begin
                chk_exp  <= (state == RD_P) ? PATTERN : ~PATTERN;
                chk_addr <= addr_rd;
            end

            err_cnt <= err_nxt;
            // err_cnt==0 marks the first increment of this run.
            if (mismatch && (err_cnt == '0)) begin
                first_fail_addr <= chk_addr;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= WR_P;
                        cnt             <= '0;
                        wr_en           <= 1'b1;
                        rd_en           <= 1'b0;
                        addr_wr         <= '0;
                        din             <= PATTERN;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_cnt         <= '0;
                        first_fail_addr <= '0;
                    end
                end

                WR_P: begin
                    if (cnt == LAST) begin
                        state   <= RD_P;
                        cnt     <= '0;
                        wr_en   <= 1'b0;
                        rd_en   <= 1'b1;
                        addr_rd <= '0;
                    end else begin
                        cnt     <= cnt + 1'b1;
                        addr_wr <= cnt + 1'b1;
                    end
                end

                RD_P: begin
                    if (cnt == LAST) begin
                        state   <= WR_NP;
                        cnt     <= LAST;
                        rd_en   <= 1'b0;
                        wr_en   <= 1'b1;
                        addr_wr <= LAST;
                        din     <= ~PATTERN;
                    end else begin
                        cnt     <= cnt + 1'b1;
                        addr_rd <= cnt + 1'b1;
                    end
                end

                WR_NP: begin
                    if (cnt == '0) begin
                        state   <= RD_NP;
                        cnt     <= LAST;
                        wr_en   <= 1'b0;
                        rd_en   <= 1'b1;
                        addr_rd <= LAST;
                    end else begin
                        cnt     <= cnt - 1'b1;
                        addr_wr <= cnt - 1'b1;
                    end
                end

                RD_NP: begin
                    if (cnt == '0) begin
                        state <= FLUSH;
                        rd_en <= 1'b0;
                    end else begin
                        cnt     <= cnt - 1'b1;
                        addr_rd <= cnt - 1'b1;
                    end
                end

                FLUSH: begin
                    // The final read's compare resolves in this cycle.
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_nxt == '0);
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
